// File: rtl/board_row_streamer_pkg.sv
// Shared board geometry, FSM encoding and helpers for the row streamer.
package board_row_streamer_pkg;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned COLS    = 16;
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned BOARD_W = ROWS * COLS;
  localparam int unsigned BASE_W  = $clog2(BOARD_W);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/board_row_streamer_if.sv
// Row-beat valid/ready stream from the streamer to a row-oriented consumer.
interface board_row_streamer_if;
  import board_row_streamer_pkg::*;

  logic             row_valid;
  logic             row_ready;
  logic [COLS-1:0]  row_data;
  logic [ROW_W-1:0] row_idx;
  logic             frame_start;
  logic             frame_end;

  modport master (
    output row_valid, row_data, row_idx, frame_start, frame_end,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_data, row_idx, frame_start, frame_end,
    output row_ready
  );

endinterface

// File: rtl/board_row_streamer.sv
// Snapshots a 16x16 Game-of-Life board on capture and streams it one row per beat.
module board_row_streamer
  import board_row_streamer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BOARD_W-1:0]   board_i,
  input  logic                 capture,
  output logic                 busy,
  board_row_streamer_if.master row,
  output logic [15:0]          frame_count,
  output logic [7:0]           drop_count
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] snap_q, snap_d;
  logic [ROW_W-1:0]   idx_q, idx_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [7:0]         drop_q, drop_d;

  logic sending, fire, last_beat;
  logic [BASE_W-1:0] base;

  assign sending   = (state_q == StSend);
  assign fire      = sending & row.row_ready;
  assign last_beat = fire & (idx_q == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      snap_q        <= '0;
      idx_q         <= '0;
      frame_count_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    drop_d        = drop_q;
    case (state_q)
      StIdle: begin
        if (capture) begin
          snap_d  = board_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (last_beat) begin
          frame_count_d = frame_count_q + 16'd1;
          // A capture on the final transfer chains straight into the next frame.
          if (capture) begin
            snap_d = board_i;
            idx_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (fire) begin
          idx_d = idx_q + ROW_W'(1);
        end
        if (capture && !last_beat) begin
          drop_d = sat_inc8(drop_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    base            = BASE_W'(idx_q) * BASE_W'(COLS);
    busy            = sending;
    row.row_valid   = sending;
    row.row_data    = snap_q[base +: COLS];
    row.row_idx     = idx_q;
    row.frame_start = sending && (idx_q == '0);
    row.frame_end   = sending && (idx_q == LAST_ROW);
    frame_count     = frame_count_q;
    drop_count      = drop_q;
  end

endmodule

// File: tb/tb_board_row_streamer.sv
// Scoreboard bench for board_row_streamer: expected rows queued at capture, checked per beat.
module tb_board_row_streamer;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
  } beat_t;

  logic         clk;
  logic         reset;
  logic [255:0] board_i;
  logic         capture;
  logic         busy;
  logic [15:0]  frame_count;
  logic [7:0]   drop_count;

  board_row_streamer_if bus ();

  board_row_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .board_i     (board_i),
    .capture     (capture),
    .busy        (busy),
    .row         (bus),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  int    total = 0;
  int    bad   = 0;
  int    xfers = 0;
  beat_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [255:0] b);
    beat_t e;
    for (int r = 0; r < 16; r++) begin
      e.idx  = 4'(r);
      e.data = b[r*16 +: 16];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic run_until_idle(input logic [3:0] pat, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      bus.row_ready = pat[i % 4];
      tick();
      if (!busy) break;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Every valid cycle is compared to the queue head, so stalled beats must hold steady.
  always @(negedge clk) begin
    if (!reset && bus.row_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'd1, 32'd0);
      end else begin
        check("row_idx", 32'(bus.row_idx), 32'(exp_q[0].idx));
        check("row_data", 32'(bus.row_data), 32'(exp_q[0].data));
        check("frame_start", 32'(bus.frame_start), 32'(exp_q[0].idx == 4'd0));
        check("frame_end", 32'(bus.frame_end), 32'(exp_q[0].idx == 4'd15));
        if (bus.row_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b;
    int           x0;
    reset         = 1'b1;
    capture       = 1'b0;
    board_i       = '0;
    bus.row_ready = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.row_valid), 32'd0);
    check("rst_data", 32'(bus.row_data), 32'd0);
    check("rst_idx", 32'(bus.row_idx), 32'd0);
    check("rst_marks", 32'({bus.frame_start, bus.frame_end}), 32'd0);
    check("rst_counts", {frame_count, 8'd0, drop_count}, 32'd0);
    #2;
    reset = 1'b0;
    tick();

    // 1: single-bit board, ready held high, latency of busy.
    board_i       = 256'h1;
    bus.row_ready = 1'b1;
    capture       = 1'b1;
    push_frame(board_i);
    tick();
    capture = 1'b0;
    check("t1_busy_rise", 32'(busy), 32'd1);
    repeat (15) tick();
    check("t1_busy_n16", 32'(busy), 32'd1);
    tick();
    check("t1_busy_n17", 32'(busy), 32'd0);
    check("t1_frames", 32'(frame_count), 32'd1);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: patterned rows, stalled handshake 1,0,0,1.
    for (int r = 0; r < 16; r++) b[r*16 +: 16] = 16'hA5A5 ^ 16'(r);
    board_i = b;
    capture = 1'b1;
    push_frame(b);
    x0 = xfers;
    tick();
    capture = 1'b0;
    board_i = ~b;
    run_until_idle(4'b1001, 200);
    check("t2_xfers", 32'(xfers - x0), 32'd16);
    check("t2_frames", 32'(frame_count), 32'd2);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: capture at row 5 is dropped; snapshot survives board_i change.
    b             = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
    board_i       = b;
    bus.row_ready = 1'b1;
    capture       = 1'b1;
    push_frame(b);
    tick();
    capture = 1'b0;
    repeat (5) tick();
    check("t3_at_row5", 32'(bus.row_idx), 32'd5);
    board_i = '1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    run_until_idle(4'b1111, 100);
    check("t3_drops", 32'(drop_count), 32'd1);
    check("t3_frames", 32'(frame_count), 32'd3);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: capture coincident with the row-15 transfer chains a new frame.
    do_reset();
    check("t4_rst_frames", 32'(frame_count), 32'd0);
    b             = {8{32'h0F0F_3C3C}};
    board_i       = b;
    bus.row_ready = 1'b1;
    capture       = 1'b1;
    push_frame(b);
    tick();
    capture = 1'b0;
    repeat (15) tick();
    check("t4_at_row15", 32'(bus.row_idx), 32'd15);
    b       = {8{32'h1234_FEDC}};
    board_i = b;
    capture = 1'b1;
    push_frame(b);
    tick();
    capture = 1'b0;
    check("t4_idx0", 32'(bus.row_idx), 32'd0);
    check("t4_start", 32'(bus.frame_start), 32'd1);
    check("t4_valid", 32'(bus.row_valid), 32'd1);
    check("t4_frames", 32'(frame_count), 32'd1);
    check("t4_drops", 32'(drop_count), 32'd0);
    run_until_idle(4'b1111, 100);
    check("t4_frames_end", 32'(frame_count), 32'd2);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: asynchronous reset while stalled at row 7.
    b             = {8{32'hDEAD_BEEF}};
    board_i       = b;
    bus.row_ready = 1'b1;
    capture       = 1'b1;
    push_frame(b);
    tick();
    capture = 1'b0;
    repeat (7) tick();
    bus.row_ready = 1'b0;
    tick();
    tick();
    check("t5_stall_row7", 32'(bus.row_idx), 32'd7);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(bus.row_valid), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_frames", 32'(frame_count), 32'd0);
    exp_q.delete();
    #2;
    reset = 1'b0;
    tick();
    b             = {8{32'h8001_7FFE}};
    board_i       = b;
    bus.row_ready = 1'b1;
    capture       = 1'b1;
    push_frame(b);
    tick();
    capture = 1'b0;
    check("t5_restart_idx", 32'(bus.row_idx), 32'd0);
    run_until_idle(4'b1111, 100);
    check("t5_frames_end", 32'(frame_count), 32'd1);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: 300 drops while stalled saturate the drop counter.
    b             = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
    board_i       = b;
    bus.row_ready = 1'b0;
    capture       = 1'b1;
    push_frame(b);
    tick();
    for (int i = 0; i < 300; i++) begin
      board_i = {8{$urandom()}};
      tick();
    end
    capture = 1'b0;
    check("t6_drops_sat", 32'(drop_count), 32'hFF);
    run_until_idle(4'b1111, 100);
    check("t6_drops_hold", 32'(drop_count), 32'hFF);
    check("t6_frames", 32'(frame_count), 32'd2);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
